// File: rtl/trigger_multi_if.sv
// trigger_multi_if: signal bundle between the ADC sample registers / control
// registers (master side) and the trigger block (slave side).
//
// There is no valid/ready handshake on this bus. Every clock carries one valid
// sample per channel, and the control fields are sampled continuously.
// trigger is a one-cycle strobe that the consumer must take in the cycle it is
// high, because it is never held or repeated.
//
// Signals:
//   adc_in          packed samples, channel i at [i*DATA_W +: DATA_W]
//   trig_slope      1 = rising trigger, 0 = falling trigger
//   trig_level      unsigned threshold
//   trig_count_req  consecutive qualifying samples needed (0 acts as 1)
//   holdoff         HOLDOFF length minus one, in cycles
//   ch_enable       per-channel permission to fire
//   single_mode     1 = stop in IDLE after holdoff, 0 = re-arm
//   arm             level-sensitive arm request, honoured in IDLE only
//   trigger         single-cycle trigger pulse
//   trig_ch         channel that caused the last trigger
//   armed           high while the FSM is in ARMED
//   dbg_state       raw FSM state encoding (0 IDLE, 1 ARMED, 2 HOLDOFF)
interface trigger_multi_if #(
  parameter int DATA_W = 14,
  parameter int N_CH   = 2,
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 16,
  parameter int CH_W   = 1
);
  logic [N_CH*DATA_W-1:0] adc_in;
  logic                   trig_slope;
  logic [DATA_W-1:0]      trig_level;
  logic [CNT_W-1:0]       trig_count_req;
  logic [HOLD_W-1:0]      holdoff;
  logic [N_CH-1:0]        ch_enable;
  logic                   single_mode;
  logic                   arm;
  logic                   trigger;
  logic [CH_W-1:0]        trig_ch;
  logic                   armed;
  logic [1:0]             dbg_state;

  modport master (
    output adc_in, trig_slope, trig_level, trig_count_req, holdoff,
           ch_enable, single_mode, arm,
    input  trigger, trig_ch, armed, dbg_state
  );

  modport slave (
    input  adc_in, trig_slope, trig_level, trig_count_req, holdoff,
           ch_enable, single_mode, arm,
    output trigger, trig_ch, armed, dbg_state
  );
endinterface

// File: rtl/trigger_multi.sv
// trigger_multi: multi-channel level/slope trigger with run-length
// qualification and an arm/holdoff state machine.
//
// Ports:
//   clk   sample clock, one sample per channel per cycle
//   rst   asynchronous active-high reset
//   bus   trigger_multi_if.slave. It carries the samples and the trigger
//         controls in, and trigger/trig_ch/armed/dbg_state out.
//
// Each channel compares its sample against the shared level. It also compares
// the sample against its own previous sample, so that only a monotonic run in
// the chosen direction qualifies. A saturating run counter measures how long
// the run has lasted. A channel hits only on the cycle its run reaches the
// required length. This means a sustained condition fires once and must break
// before it can fire again.
module trigger_multi #(
  parameter int DATA_W = 14,
  parameter int N_CH   = 2,
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 16,
  parameter int CH_W   = 1
) (
  input logic             clk,
  input logic             rst,
  trigger_multi_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t              state;
  logic                trigReg;
  logic [CH_W-1:0]     trigChReg;
  logic                armedReg;
  logic [HOLD_W-1:0]   holdCnt;

  logic [DATA_W-1:0]   lastVal [N_CH];
  logic [CNT_W-1:0]    runCnt  [N_CH];

  logic [DATA_W-1:0]   sample  [N_CH];
  logic [CNT_W-1:0]    cntNext [N_CH];
  logic [N_CH-1:0]     cond;
  logic [N_CH-1:0]     hit;
  logic [CNT_W-1:0]    nEff;
  logic                anyHit;
  logic [CH_W-1:0]     hitIdx;

  // Qualification and run counting
  always_comb begin
    nEff = (bus.trig_count_req == '0) ? CNT_W'(1) : bus.trig_count_req;
    cond = '0;
    hit  = '0;
    for (int i = 0; i < N_CH; i++) begin
      sample[i] = bus.adc_in[i*DATA_W +: DATA_W];
      if (bus.trig_slope)
        cond[i] = (sample[i] > bus.trig_level) && (sample[i] >= lastVal[i]);
      else
        cond[i] = (sample[i] < bus.trig_level) && (sample[i] <= lastVal[i]);

      // Saturate rather than wrap. A wrap would let a long run pass through
      // nEff a second time and fire again.
      if (!cond[i])
        cntNext[i] = '0;
      else if (runCnt[i] == {CNT_W{1'b1}})
        cntNext[i] = runCnt[i];
      else
        cntNext[i] = runCnt[i] + CNT_W'(1);

      hit[i] = bus.ch_enable[i] && (cntNext[i] == nEff);
    end
  end

  // Fixed priority: the lowest channel index wins.
  always_comb begin
    hitIdx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (hit[i]) hitIdx = CH_W'(i);
    end
    anyHit = |hit;
  end

  // The per-channel history runs in every state. Hits seen outside ARMED are
  // therefore consumed, not deferred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        lastVal[i] <= '0;
        runCnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        lastVal[i] <= sample[i];
        runCnt[i]  <= cntNext[i];
      end
    end
  end

  // Arm / fire / holdoff state machine. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      trigReg   <= 1'b0;
      trigChReg <= '0;
      armedReg  <= 1'b0;
      holdCnt   <= '0;
    end else begin
      trigReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.arm) begin
            state    <= ARMED;
            armedReg <= 1'b1;
          end
        end
        ARMED: begin
          if (anyHit) begin
            trigReg   <= 1'b1;
            trigChReg <= hitIdx;
            holdCnt   <= bus.holdoff;
            state     <= HOLDOFF;
            armedReg  <= 1'b0;
          end
        end
        HOLDOFF: begin
          // The counter is tested before it is decremented, so HOLDOFF lasts
          // holdoff+1 cycles.
          if (holdCnt == '0) begin
            if (bus.single_mode) begin
              state    <= IDLE;
              armedReg <= 1'b0;
            end else begin
              state    <= ARMED;
              armedReg <= 1'b1;
            end
          end else begin
            holdCnt <= holdCnt - HOLD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          armedReg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trigger   = trigReg;
  assign bus.trig_ch   = trigChReg;
  assign bus.armed     = armedReg;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_trigger_multi.sv
// Directed bench for trigger_multi with two channels. Inputs change 1 ns after
// the rising edge, and outputs are checked at that same point.
module tb_trigger_multi;

  localparam int DATA_W = 14;
  localparam int N_CH   = 2;
  localparam int CNT_W  = 8;
  localparam int HOLD_W = 16;
  localparam int CH_W   = 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   trig_seen;

  trigger_multi_if #(
    .DATA_W(DATA_W), .N_CH(N_CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W), .CH_W(CH_W)
  ) bus ();

  trigger_multi #(
    .DATA_W(DATA_W), .N_CH(N_CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W), .CH_W(CH_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_adc(input int ch, input logic [DATA_W-1:0] v);
    bus.adc_in[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    trig_seen = 0;
    rst = 1'b1;
    bus.adc_in = '0;
    bus.trig_slope = 1'b1;
    bus.trig_level = 14'd1000;
    bus.trig_count_req = 8'd2;
    bus.holdoff = 16'd3;
    bus.ch_enable = 2'b11;
    bus.single_mode = 1'b1;
    bus.arm = 1'b0;
    #22;
    chk("reset_trigger", 32'(bus.trigger), 0);
    chk("reset_trig_ch", 32'(bus.trig_ch), 0);
    chk("reset_armed", 32'(bus.armed), 0);
    chk("reset_state", 32'(bus.dbg_state), 0);
    rst = 1'b0;
    tick();

    // Rising slope, req=2, ch0 900/1100/1200/1300
    do_arm();
    chk("t1_armed", 32'(bus.armed), 1);
    set_adc(0, 900);  tick(); chk("t1_900", 32'(bus.trigger), 0);
    set_adc(0, 1100); tick(); chk("t1_1100", 32'(bus.trigger), 0);
    set_adc(0, 1200); tick();
    chk("t1_fire", 32'(bus.trigger), 1);
    chk("t1_ch", 32'(bus.trig_ch), 0);
    chk("t1_armed_off", 32'(bus.armed), 0);
    set_adc(0, 1300); tick(); chk("t1_no_refire", 32'(bus.trigger), 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t1_holdoff_quiet", 32'(bus.trigger), 0);
    end
    chk("t1_single_idle", 32'(bus.dbg_state), 0);
    set_adc(0, 0); tick();

    // Falling slope, req=3, ch1 run broken by the 350 rise
    bus.trig_slope = 1'b0;
    bus.trig_level = 14'd500;
    bus.trig_count_req = 8'd3;
    set_adc(0, 1000);
    set_adc(1, 600);
    do_arm();
    set_adc(1, 400); tick(); chk("t2_400", 32'(bus.trigger), 0);
    set_adc(1, 300); tick(); chk("t2_300", 32'(bus.trigger), 0);
    set_adc(1, 350); tick(); chk("t2_350", 32'(bus.trigger), 0);
    set_adc(1, 200); tick(); chk("t2_200", 32'(bus.trigger), 0);
    set_adc(1, 100); tick(); chk("t2_100", 32'(bus.trigger), 0);
    set_adc(1, 50);  tick();
    chk("t2_fire", 32'(bus.trigger), 1);
    chk("t2_ch", 32'(bus.trig_ch), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t2_idle", 32'(bus.dbg_state), 0);

    // Simultaneous hits, req=1
    bus.trig_slope = 1'b1;
    bus.trig_level = 14'd1000;
    bus.trig_count_req = 8'd1;
    set_adc(0, 0); set_adc(1, 0);
    tick();
    do_arm();
    set_adc(0, 2000); set_adc(1, 2000); tick();
    chk("t3_fire", 32'(bus.trigger), 1);
    chk("t3_ch_low", 32'(bus.trig_ch), 0);
    tick(); chk("t3_one_pulse", 32'(bus.trigger), 0);
    for (int i = 0; i < 3; i++) tick();
    set_adc(0, 0); set_adc(1, 0);
    bus.ch_enable = 2'b10;
    tick();
    do_arm();
    set_adc(0, 2000); set_adc(1, 2000); tick();
    chk("t3_fire_en10", 32'(bus.trigger), 1);
    chk("t3_ch_en10", 32'(bus.trig_ch), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t3_idle", 32'(bus.dbg_state), 0);
    bus.ch_enable = 2'b11;
    set_adc(0, 0); set_adc(1, 0);
    tick();

    // Continuous mode: the burst inside holdoff is dropped, the later one fires
    bus.single_mode = 1'b0;
    do_arm();
    set_adc(0, 2000); tick();
    chk("t4_fire0", 32'(bus.trigger), 1);
    for (int i = 1; i <= 9; i++) begin
      set_adc(0, (i == 2) ? 14'd2000 : 14'd0);
      tick();
      chk("t4_quiet", 32'(bus.trigger), 0);
      chk("t4_armed", 32'(bus.armed), (i >= 4) ? 1 : 0);
    end
    set_adc(0, 2000); tick();
    chk("t4_fire1", 32'(bus.trigger), 1);
    bus.single_mode = 1'b1;
    set_adc(0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("t4_hold_quiet", 32'(bus.trigger), 0);
    end
    chk("t4_single_idle", 32'(bus.dbg_state), 0);
    chk("t4_single_unarmed", 32'(bus.armed), 0);
    set_adc(0, 2000); tick();
    chk("t4_no_arm_no_fire", 32'(bus.trigger), 0);
    set_adc(0, 0); tick();

    // req=0 acts as 1. A 300-cycle ramp fires once, with no wrap re-fire.
    bus.trig_count_req = 8'd0;
    bus.single_mode = 1'b0;
    do_arm();
    for (int i = 0; i < 300; i++) begin
      set_adc(0, 14'(1100 + i));
      tick();
      if (i == 0) chk("t5_req0_fire", 32'(bus.trigger), 1);
      if (bus.trigger === 1'b1) trig_seen++;
    end
    chk("t5_one_trigger", 32'(trig_seen), 1);
    chk("t5_rearmed", 32'(bus.armed), 1);

    // Asynchronous reset while trigger=1 and in HOLDOFF
    set_adc(0, 0); set_adc(1, 2000); tick();
    chk("t6_fire", 32'(bus.trigger), 1);
    chk("t6_ch", 32'(bus.trig_ch), 1);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_trigger", 32'(bus.trigger), 0);
    chk("t6_rst_armed", 32'(bus.armed), 0);
    chk("t6_rst_ch", 32'(bus.trig_ch), 0);
    chk("t6_rst_state", 32'(bus.dbg_state), 0);
    tick(); tick();
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_adc(1, (i % 2 == 0) ? 14'd0 : 14'd2000);
      tick();
      chk("t6_no_fire_unarmed", 32'(bus.trigger), 0);
    end
    set_adc(1, 0);
    do_arm();
    set_adc(1, 2000); tick();
    chk("t6_fire_after_arm", 32'(bus.trigger), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
